// File: rtl/jk_register_bank_pkg.sv
// Shared types and helpers for the JK register bank.
package jk_bank_pkg;

    // Per-cycle update mode; all four encodings are meaningful.
    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    // Widest vector popcount accepts; narrower callers zero-extend.
    localparam int unsigned POP_MAX_W = 256;

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/jk_register_bank_if.sv
// Control/data bundle for the JK register bank.
interface jk_register_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             cnt_clr;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [CNT_W-1:0] toggle_cnt;
    logic             sr_err;

    // Driver side (stimulus / host).
    modport master (
        output en, mode, j, k, load, load_data, cnt_clr, err_clr,
        input  q, q_bar, toggle_cnt, sr_err
    );

    // Register bank side.
    modport slave (
        input  en, mode, j, k, load, load_data, cnt_clr, err_clr,
        output q, q_bar, toggle_cnt, sr_err
    );
endinterface

// File: rtl/jk_register_bank_next_bit.sv
// Combinational next-state for one flip-flop bit under the selected mode.
module jk_next_bit
    import jk_bank_pkg::*;
(
    input  logic  q_i,
    input  logic  j_i,
    input  logic  k_i,
    input  mode_e mode_i,
    output logic  nxt_o,
    output logic  sr_conflict_o
);

    // Decode mode and inputs; every unlisted combination holds.
    always_comb begin
        nxt_o         = q_i;
        sr_conflict_o = 1'b0;
        case (mode_i)
            MODE_JK: begin
                case ({j_i, k_i})
                    2'b01:   nxt_o = 1'b0;
                    2'b10:   nxt_o = 1'b1;
                    2'b11:   nxt_o = ~q_i;
                    default: nxt_o = q_i;
                endcase
            end
            MODE_D: begin
                nxt_o = j_i;
            end
            MODE_T: begin
                nxt_o = j_i ? ~q_i : q_i;
            end
            MODE_SR: begin
                case ({j_i, k_i})
                    2'b10:   nxt_o = 1'b1;
                    2'b01:   nxt_o = 1'b0;
                    2'b11: begin
                        nxt_o         = q_i;
                        sr_conflict_o = 1'b1;
                    end
                    default: nxt_o = q_i;
                endcase
            end
            default: begin
                nxt_o = q_i;
            end
        endcase
    end

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of mode-selectable flip-flops with parallel load,
// saturating transition counter and sticky SR-conflict flag.
module jk_register_bank
    import jk_bank_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      CNT_W       = 16
) (
    input logic               clk,
    input logic               reset,
    jk_register_bank_if.slave bus
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sr_err_q;
    logic             sr_err_d;

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] conflict;
    logic [WIDTH-1:0] diff;
    logic [CNT_W:0]   pop;
    logic [CNT_W:0]   sum;
    logic             err_set;
    mode_e            mode_s;

    assign mode_s = mode_e'(bus.mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_next_bit u_bit (
            .q_i           (q_q[i]),
            .j_i           (bus.j[i]),
            .k_i           (bus.k[i]),
            .mode_i        (mode_s),
            .nxt_o         (nxt[i]),
            .sr_conflict_o (conflict[i])
        );
    end

    // Next-state selection: load beats enable beats hold; counter adds
    // transitions in CNT_W+1 bits then clamps; flag set beats clear.
    always_comb begin
        q_d = q_q;
        if (bus.load) begin
            q_d = bus.load_data;
        end else if (bus.en) begin
            q_d = nxt;
        end

        diff = q_d ^ q_q;
        pop  = (CNT_W+1)'(popcount(POP_MAX_W'(diff)));
        sum  = {1'b0, cnt_q} + pop;

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (sum[CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end

        err_set = bus.en && !bus.load && (|conflict);
        if (err_set) begin
            sr_err_d = 1'b1;
        end else if (bus.err_clr) begin
            sr_err_d = 1'b0;
        end else begin
            sr_err_d = sr_err_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q      <= RESET_VALUE;
            cnt_q    <= '0;
            sr_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            sr_err_q <= sr_err_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.q_bar      = ~q_q;
    assign bus.toggle_cnt = cnt_q;
    assign bus.sr_err     = sr_err_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Bench for jk_register_bank: two instances (16-bit and 4-bit counters)
// share stimulus and are checked each cycle against a behavioural model.
module tb_jk_register_bank;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    jk_register_bank_if #(.WIDTH(8), .CNT_W(16)) ifa ();
    jk_register_bank_if #(.WIDTH(8), .CNT_W(4))  ifb ();

    jk_register_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    jk_register_bank #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_W(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [7:0] mq_a, mq_b;
    int         mcnt_a, mcnt_b;
    logic       merr_a, merr_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] q, input logic [7:0] j,
                                              input logic [7:0] k, input int m,
                                              output logic conflict);
        logic [7:0] n;
        n = q;
        conflict = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m == 0) begin
                if (j[i] && k[i]) n[i] = !q[i];
                else if (j[i])    n[i] = 1'b1;
                else if (k[i])    n[i] = 1'b0;
            end else if (m == 1) begin
                n[i] = j[i];
            end else if (m == 2) begin
                if (j[i]) n[i] = !q[i];
            end else begin
                if (j[i] && !k[i])      n[i] = 1'b1;
                else if (!j[i] && k[i]) n[i] = 1'b0;
                else if (j[i] && k[i])  conflict = 1'b1;
            end
        end
        return n;
    endfunction

    // Model update: both instances see identical inputs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq_a = 8'hA5; mcnt_a = 0; merr_a = 1'b0;
            mq_b = 8'h00; mcnt_b = 0; merr_b = 1'b0;
        end else begin
            logic [7:0] na, nb;
            logic       ca, cb;
            int         sa, sb;
            na = model_next(mq_a, ifa.j, ifa.k, int'(ifa.mode), ca);
            nb = model_next(mq_b, ifb.j, ifb.k, int'(ifb.mode), cb);
            if (ifa.load)     na = ifa.load_data;
            else if (!ifa.en) na = mq_a;
            if (ifb.load)     nb = ifb.load_data;
            else if (!ifb.en) nb = mq_b;
            sa = mcnt_a + $countones(na ^ mq_a);
            sb = mcnt_b + $countones(nb ^ mq_b);
            if (sa > 65535) sa = 65535;
            if (sb > 15)    sb = 15;
            if (ifa.cnt_clr) sa = 0;
            if (ifb.cnt_clr) sb = 0;
            if (ifa.en && !ifa.load && ca) merr_a = 1'b1;
            else if (ifa.err_clr)          merr_a = 1'b0;
            if (ifb.en && !ifb.load && cb) merr_b = 1'b1;
            else if (ifb.err_clr)          merr_b = 1'b0;
            mq_a = na; mcnt_a = sa;
            mq_b = nb; mcnt_b = sb;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("a_q",    {24'b0, ifa.q},          {24'b0, mq_a});
        chk("a_qbar", {24'b0, ifa.q_bar},      {24'b0, ~mq_a});
        chk("a_cnt",  {16'b0, ifa.toggle_cnt}, 32'(mcnt_a));
        chk("a_err",  {31'b0, ifa.sr_err},     {31'b0, merr_a});
        chk("b_q",    {24'b0, ifb.q},          {24'b0, mq_b});
        chk("b_qbar", {24'b0, ifb.q_bar},      {24'b0, ~mq_b});
        chk("b_cnt",  {28'b0, ifb.toggle_cnt}, 32'(mcnt_b));
        chk("b_err",  {31'b0, ifb.sr_err},     {31'b0, merr_b});
    end

    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] jj,
                         input logic [7:0] kk, input logic ld, input logic [7:0] ldd,
                         input logic cc, input logic ec);
        ifa.en = e; ifa.mode = m; ifa.j = jj; ifa.k = kk;
        ifa.load = ld; ifa.load_data = ldd; ifa.cnt_clr = cc; ifa.err_clr = ec;
        ifb.en = e; ifb.mode = m; ifb.j = jj; ifb.k = kk;
        ifb.load = ld; ifb.load_data = ldd; ifb.cnt_clr = cc; ifb.err_clr = ec;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_a(input string name, input logic [7:0] q, input int cnt, input logic err);
        chk({name, "_q"},    {24'b0, ifa.q},          {24'b0, q});
        chk({name, "_qbar"}, {24'b0, ifa.q_bar},      {24'b0, ~q});
        chk({name, "_cnt"},  {16'b0, ifa.toggle_cnt}, 32'(cnt));
        chk({name, "_err"},  {31'b0, ifa.sr_err},     {31'b0, err});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        chk_a("rst_a", 8'hA5, 0, 1'b0);
        chk("rst_b_q", {24'b0, ifb.q}, 32'h00);
        reset = 1'b0;
        tick();

        // Bring A to zero; the load's transitions are discarded by cnt_clr.
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0); tick();
        chk_a("clr0", 8'h00, 0, 1'b0);

        // JK set/clear, toggle, hold.
        drive(1'b1, 2'b00, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("jk1", 8'hF0, 4, 1'b0);
        drive(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("jk2", 8'h0F, 12, 1'b0);
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("jk3", 8'h0F, 12, 1'b0);

        // D then T; narrow counter saturates at 15.
        drive(1'b1, 2'b01, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("d1", 8'h3C, 16, 1'b0);
        chk("sat_b_d1", {28'b0, ifb.toggle_cnt}, 32'd15);
        drive(1'b1, 2'b10, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("t1", 8'h3D, 17, 1'b0);
        tick();
        chk_a("t2", 8'h3C, 18, 1'b0);
        tick();
        chk_a("t3", 8'h3D, 19, 1'b0);
        drive(1'b0, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("en0", 8'h3D, 19, 1'b0);

        // SR conflict, set beats clear, clear alone.
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0); tick();
        chk_a("clr1", 8'h00, 0, 1'b0);
        drive(1'b1, 2'b11, 8'h81, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("sr1", 8'h80, 1, 1'b1);
        drive(1'b1, 2'b11, 8'h81, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1); tick();
        chk_a("sr2", 8'h80, 1, 1'b1);
        drive(1'b0, 2'b11, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1); tick();
        chk_a("sr3", 8'h80, 1, 1'b0);

        // Load priority over enabled JK toggles; cnt_clr wins over transitions.
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0); tick();
        chk_a("clr2", 8'h00, 0, 1'b0);
        drive(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0); tick();
        chk_a("ld1", 8'hFF, 8, 1'b0);
        drive(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0); tick();
        chk_a("cc1", 8'h00, 0, 1'b0);

        // Saturation of the 4-bit counter.
        drive(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk("sat_b1", {28'b0, ifb.toggle_cnt}, 32'd8);
        tick();
        chk("sat_b2", {28'b0, ifb.toggle_cnt}, 32'd15);
        chk_a("sat_a2", 8'h00, 16, 1'b0);
        tick();
        chk("sat_b3", {28'b0, ifb.toggle_cnt}, 32'd15);
        chk_a("sat_a3", 8'hFF, 24, 1'b0);
        drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        chk_a("pre_rst", 8'hFF, 24, 1'b1);

        // Asynchronous reset between edges, then held across an edge.
        drive(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_a("arst", 8'hA5, 0, 1'b0);
        chk("arst_b_q",   {24'b0, ifb.q},          32'h00);
        chk("arst_b_cnt", {28'b0, ifb.toggle_cnt}, 32'd0);
        chk("arst_b_err", {31'b0, ifb.sr_err},     32'd0);
        tick();
        chk_a("hold_rst", 8'hA5, 0, 1'b0);
        reset = 1'b0;
        tick();
        chk_a("post_rst", 8'h5A, 8, 1'b0);
        chk("post_rst_b_q", {24'b0, ifb.q}, 32'hFF);

        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
